// File: rtl/gpio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_ctrl_pkg
// Purpose  : Shared constants, sequencer state type and helpers for the GPIO
//            bank controller.
// Revision : 1.0  initial release
// ============================================================================
package gpio_ctrl_pkg;

  // Write targets on the configuration port
  localparam logic [1:0] ADDR_OUT     = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN  = 2'd2;
  localparam logic [1:0] ADDR_IRQ_CLR = 2'd3;

  // Read selects on the readback port
  localparam logic [1:0] RD_IN      = 2'd0;
  localparam logic [1:0] RD_DIR     = 2'd1;
  localparam logic [1:0] RD_IRQ_EN  = 2'd2;
  localparam logic [1:0] RD_PENDING = 2'd3;

  // Direction-change sequencer states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DRIVE_OFF = 2'd1,
    TURN      = 2'd2,
    APPLY     = 2'd3
  } state_t;

  // Larger of two integers, used to size the shared counter width
  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : gpio_sync_edge
// Purpose  : Two-flop synchroniser for a vector of asynchronous pad inputs,
//            plus a history flop giving a one-cycle rising-edge strobe.
// Revision : 1.0  initial release
// ============================================================================
module gpio_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;

  // Metastability chain followed by the previous-value flop
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/gpio_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpio_bank_ctrl
// Purpose  : Register-controlled GPIO bank with break-before-make direction
//            turnaround, synchronised inputs and rising-edge level interrupt.
// Revision : 1.0  initial release
// ============================================================================
module gpio_bank_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int NUM_PINS      = 8,
  parameter int TURN_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [1:0]          i_cfg_addr,
  input  logic [NUM_PINS-1:0] i_cfg_wdata,
  input  logic [1:0]          i_rd_addr,
  output logic [NUM_PINS-1:0] o_rd_data,
  output logic                o_busy,
  output logic                o_irq,
  output logic [NUM_PINS-1:0] o_cell_o,
  output logic [NUM_PINS-1:0] o_cell_oe,
  output logic [NUM_PINS-1:0] o_cell_ie,
  input  logic [NUM_PINS-1:0] i_cell_i
);

  localparam int            CW            = $clog2(f_max(TURN_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CW-1:0] c_TURN_LOAD   = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] c_SETTLE_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] c_ONE         = CW'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [NUM_PINS-1:0] r_out;
  logic [NUM_PINS-1:0] r_dir;
  logic [NUM_PINS-1:0] r_irq_en;
  logic [NUM_PINS-1:0] r_pending;
  logic [NUM_PINS-1:0] r_chg;
  logic [NUM_PINS-1:0] r_newdir;
  logic [NUM_PINS-1:0] r_smask;
  logic [CW-1:0]       r_turn_cnt;
  logic [CW-1:0]       r_settle_cnt;
  logic                r_irq;

  logic                w_idle;
  logic                w_wr;
  logic [NUM_PINS-1:0] w_chg;
  logic                w_dir_start;
  logic [NUM_PINS-1:0] w_clr;
  logic [NUM_PINS-1:0] w_set;
  logic [NUM_PINS-1:0] w_sync;
  logic [NUM_PINS-1:0] w_rise;

  gpio_sync_edge #(
    .WIDTH (NUM_PINS)
  ) u_sync_edge (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_async   (i_cell_i),
    .o_sync    (w_sync),
    .o_rise    (w_rise)
  );

  // Writes are only taken while no turnaround is in flight; a held request
  // simply waits for the first idle cycle.
  assign w_idle      = (r_state == IDLE);
  assign o_cfg_ready = w_idle;
  assign w_wr        = i_cfg_valid & w_idle;
  assign w_chg       = i_cfg_wdata ^ r_dir;
  assign w_dir_start = w_wr && (i_cfg_addr == ADDR_DIR) && (|w_chg);
  assign w_clr       = (w_wr && (i_cfg_addr == ADDR_IRQ_CLR)) ? i_cfg_wdata : '0;
  // Edges are ignored while sequencing and on freshly turned pins
  assign w_set       = w_idle ? (w_rise & r_irq_en & ~r_dir & ~r_smask) : '0;
  assign o_cell_o    = r_out;
  assign o_irq       = r_irq;

  // Sequencer state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state and pad-control decode; changed pins are parked (oe=0, ie=0)
  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b1;
    o_cell_oe    = r_dir & ~r_chg;
    o_cell_ie    = ~r_chg;
    case (r_state)
      IDLE: begin
        o_busy    = 1'b0;
        o_cell_oe = r_dir;
        o_cell_ie = '1;
        if (w_dir_start) w_next_state = DRIVE_OFF;
      end
      DRIVE_OFF: w_next_state = TURN;
      TURN:      if (r_turn_cnt == '0) w_next_state = APPLY;
      APPLY:     w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  // Turnaround counter, loaded on entry to the turn phase, saturating at 0
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_turn_cnt <= '0;
    end else if (r_state == DRIVE_OFF) begin
      r_turn_cnt <= c_TURN_LOAD;
    end else if ((r_state == TURN) && (r_turn_cnt != '0)) begin
      r_turn_cnt <= r_turn_cnt - c_ONE;
    end
  end

  // Programmable registers and pending direction change
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_out    <= '0;
      r_dir    <= '0;
      r_irq_en <= '0;
      r_chg    <= '0;
      r_newdir <= '0;
    end else begin
      if (w_wr && (i_cfg_addr == ADDR_OUT))    r_out    <= i_cfg_wdata;
      if (w_wr && (i_cfg_addr == ADDR_IRQ_EN)) r_irq_en <= i_cfg_wdata;
      if (w_dir_start) begin
        r_newdir <= i_cfg_wdata;
        r_chg    <= w_chg;
      end
      if (r_state == APPLY) r_dir <= r_newdir;
    end
  end

  // Post-turnaround settle window: mask replaced per sequence, dropped at 0
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_smask      <= '0;
      r_settle_cnt <= '0;
    end else if (r_state == APPLY) begin
      r_smask      <= r_chg;
      r_settle_cnt <= c_SETTLE_LOAD;
    end else if (r_settle_cnt != '0) begin
      r_settle_cnt <= r_settle_cnt - c_ONE;
    end else begin
      r_smask      <= '0;
    end
  end

  // Pending flags (a set beats a same-cycle clear) and registered interrupt
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_irq     <= |r_pending;
    end
  end

  // Combinational readback
  always_comb begin
    o_rd_data = w_sync;
    case (i_rd_addr)
      RD_IN:      o_rd_data = w_sync;
      RD_DIR:     o_rd_data = r_dir;
      RD_IRQ_EN:  o_rd_data = r_irq_en;
      RD_PENDING: o_rd_data = r_pending;
      default:    o_rd_data = w_sync;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_bank_ctrl
// Purpose  : Self-checking bench for gpio_bank_ctrl: directed vector table,
//            hand-written interrupt/settle/reset sequences and a random phase,
//            all cross-checked against a cycle-count reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_gpio_bank_ctrl;
  import gpio_ctrl_pkg::*;

  localparam int NP = 8;
  localparam int TC = 2;
  localparam int SC = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_addr = 2'd0;
  logic [NP-1:0] cfg_wdata = '0;
  logic [1:0]    rd_addr = RD_DIR;
  logic [NP-1:0] pad = '0;
  logic          cfg_ready;
  logic [NP-1:0] rd_data;
  logic          busy;
  logic          irq;
  logic [NP-1:0] cell_o;
  logic [NP-1:0] cell_oe;
  logic [NP-1:0] cell_ie;
  logic [NP-1:0] cell_i;

  // Pad model: an input buffer with ie=0 presents 0 to the core
  assign cell_i = pad & cell_ie;

  always #5 clk = ~clk;

  gpio_bank_ctrl #(
    .NUM_PINS      (NP),
    .TURN_CYCLES   (TC),
    .SETTLE_CYCLES (SC)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_addr  (cfg_addr),
    .i_cfg_wdata (cfg_wdata),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_busy      (busy),
    .o_irq       (irq),
    .o_cell_o    (cell_o),
    .o_cell_oe   (cell_oe),
    .o_cell_ie   (cell_ie),
    .i_cell_i    (cell_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Sequencing is tracked as "cycles of busy left"; the input path as a
  // history of sampled pad values (newest first).
  logic [NP-1:0] m_out, m_dir, m_en, m_pend, m_chg, m_newdir, m_smask;
  logic          m_irq, m_acc;
  int            m_seq, m_settle;
  logic [NP-1:0] m_hist[$];

  task automatic m_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_pend = '0;
    m_chg = '0; m_newdir = '0; m_smask = '0;
    m_irq = 1'b0; m_acc = 1'b0; m_seq = 0; m_settle = 0;
    m_hist = '{8'h00, 8'h00, 8'h00};
  endtask

  function automatic logic [NP-1:0] m_ie();
    return (m_seq > 0) ? ~m_chg : 8'hFF;
  endfunction

  function automatic logic [NP-1:0] m_oe();
    return (m_seq > 0) ? (m_dir & ~m_chg) : m_dir;
  endfunction

  task automatic m_edge(input logic v, input logic [1:0] a, input logic [NP-1:0] d,
                        input logic [NP-1:0] pd);
    logic [NP-1:0] eff, rise, mask, setb, clr;
    logic          was_busy, irq_n;
    was_busy = (m_seq > 0);
    eff      = pd & m_ie();
    rise     = m_hist[1] & ~m_hist[2];
    mask     = (m_settle > 0) ? m_smask : 8'h00;
    setb     = was_busy ? 8'h00 : (rise & m_en & ~m_dir & ~mask);
    clr      = 8'h00;
    irq_n    = (m_pend != 8'h00);
    m_acc    = v && !was_busy;
    if (was_busy && m_seq == 1) begin
      m_dir    = m_newdir;
      m_smask  = m_chg;
      m_settle = SC + 1;
    end else if (m_settle > 0) begin
      m_settle--;
    end
    if (was_busy) m_seq--;
    if (m_acc) begin
      case (a)
        2'd0: m_out = d;
        2'd1: if ((d ^ m_dir) != 8'h00) begin
                m_chg = d ^ m_dir; m_newdir = d; m_seq = TC + 2;
              end
        2'd2: m_en = d;
        default: clr = d;
      endcase
    end
    m_pend = (m_pend & ~clr) | setb;
    m_irq  = irq_n;
    m_hist.push_front(eff);
    void'(m_hist.pop_back());
  endtask

  task automatic m_check();
    logic [NP-1:0] exp_rd;
    case (rd_addr)
      2'd0:    exp_rd = m_hist[1];
      2'd1:    exp_rd = m_dir;
      2'd2:    exp_rd = m_en;
      default: exp_rd = m_pend;
    endcase
    chk("m_ready",   8'(cfg_ready), 8'(m_seq == 0));
    chk("m_busy",    8'(busy),      8'(m_seq > 0));
    chk("m_cell_o",  cell_o,        m_out);
    chk("m_cell_oe", cell_oe,       m_oe());
    chk("m_cell_ie", cell_ie,       m_ie());
    chk("m_irq",     8'(irq),       8'(m_irq));
    chk("m_rd_data", rd_data,       exp_rd);
  endtask

  // One clock: model follows the edge, outputs are checked 1 ns later
  task automatic cyc();
    @(posedge clk);
    m_edge(cfg_valid, cfg_addr, cfg_wdata, pad);
    #1;
    m_check();
  endtask

  task automatic wr(input logic [1:0] a, input logic [NP-1:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc();
    cfg_valid = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          v;
    logic [1:0]    a;
    logic [NP-1:0] d;
    logic [1:0]    rd;
    logic          rdy;
    logic          bsy;
    logic [NP-1:0] oe;
    logic [NP-1:0] ie;
    logic [NP-1:0] o;
    logic [NP-1:0] rdd;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 2'd0, 8'hA5, RD_DIR,    1'b1, 1'b0, 8'h00, 8'hFF, 8'hA5, 8'h00};
    tbl[2]  = '{1'b1, 2'd1, 8'h0F, RD_DIR,    1'b0, 1'b1, 8'h00, 8'hF0, 8'hA5, 8'h00};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b0, 1'b1, 8'h00, 8'hF0, 8'hA5, 8'h00};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b0, 1'b1, 8'h00, 8'hF0, 8'hA5, 8'h00};
    tbl[5]  = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b0, 1'b1, 8'h00, 8'hF0, 8'hA5, 8'h00};
    tbl[6]  = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b1, 1'b0, 8'h0F, 8'hFF, 8'hA5, 8'h0F};
    tbl[7]  = '{1'b1, 2'd1, 8'h3C, RD_DIR,    1'b0, 1'b1, 8'h0C, 8'hCC, 8'hA5, 8'h0F};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b0, 1'b1, 8'h0C, 8'hCC, 8'hA5, 8'h0F};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b0, 1'b1, 8'h0C, 8'hCC, 8'hA5, 8'h0F};
    tbl[10] = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b0, 1'b1, 8'h0C, 8'hCC, 8'hA5, 8'h0F};
    tbl[11] = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b1, 1'b0, 8'h3C, 8'hFF, 8'hA5, 8'h3C};
    tbl[12] = '{1'b1, 2'd1, 8'h00, RD_DIR,    1'b0, 1'b1, 8'h00, 8'hC3, 8'hA5, 8'h3C};
    tbl[13] = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b0, 1'b1, 8'h00, 8'hC3, 8'hA5, 8'h3C};
    tbl[14] = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b0, 1'b1, 8'h00, 8'hC3, 8'hA5, 8'h3C};
    tbl[15] = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b0, 1'b1, 8'h00, 8'hC3, 8'hA5, 8'h3C};
    tbl[16] = '{1'b0, 2'd0, 8'h00, RD_DIR,    1'b1, 1'b0, 8'h00, 8'hFF, 8'hA5, 8'h00};
    tbl[17] = '{1'b1, 2'd2, 8'h80, RD_IRQ_EN, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hA5, 8'h80};

    // Reset
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_oe",    cell_oe,         8'h00);
    chk("rst_ie",    cell_ie,         8'hFF);
    chk("rst_o",     cell_o,          8'h00);
    chk("rst_irq",   8'(irq),         8'h00);
    chk("rst_ready", 8'(cfg_ready),   8'h01);
    chk("rst_dir",   rd_data,         8'h00);

    // Table: OUT write, two direction changes and a return to all-inputs
    for (int i = 0; i < 18; i++) begin
      cfg_valid = tbl[i].v; cfg_addr = tbl[i].a; cfg_wdata = tbl[i].d; rd_addr = tbl[i].rd;
      cyc();
      chk($sformatf("t%0d_ready", i), 8'(cfg_ready), 8'(tbl[i].rdy));
      chk($sformatf("t%0d_busy",  i), 8'(busy),      8'(tbl[i].bsy));
      chk($sformatf("t%0d_oe",    i), cell_oe,       tbl[i].oe);
      chk($sformatf("t%0d_ie",    i), cell_ie,       tbl[i].ie);
      chk($sformatf("t%0d_o",     i), cell_o,        tbl[i].o);
      chk($sformatf("t%0d_rd",    i), rd_data,       tbl[i].rdd);
    end
    cfg_valid = 1'b0;

    // Interrupt latency on pin 7, set-beats-clear, then clear
    rd_addr = RD_PENDING;
    pad = 8'h80;
    cyc(); chk("pend_e1", rd_data, 8'h00);
    cyc(); chk("pend_e2", rd_data, 8'h00);
    cyc(); chk("pend_e3", rd_data, 8'h80); chk("irq_e3", 8'(irq), 8'h00);
    cyc(); chk("irq_e4", 8'(irq), 8'h01);
    pad = 8'h00;
    repeat (4) cyc();
    pad = 8'h80;
    cyc(); cyc();
    wr(ADDR_IRQ_CLR, 8'h80); chk("set_wins", rd_data, 8'h80);
    cyc();
    wr(ADDR_IRQ_CLR, 8'h80); chk("clr_pend", rd_data, 8'h00); chk("irq_lag", 8'(irq), 8'h01);
    cyc(); chk("irq_clr", 8'(irq), 8'h00);

    // Pin 1 output->input with its pad high: turnaround glitch must be masked
    pad = 8'h02;
    wr(ADDR_IRQ_EN, 8'h02);
    wr(ADDR_DIR, 8'h02);
    repeat (10) cyc();
    wr(ADDR_DIR, 8'h00);
    chk("settle_w", rd_data, 8'h00);
    for (int i = 0; i < 14; i++) begin
      cyc();
      chk($sformatf("settle_%0d", i), rd_data, 8'h00);
    end
    pad = 8'h00;
    repeat (4) cyc();
    pad = 8'h02;
    cyc(); cyc(); cyc();
    chk("post_settle", rd_data, 8'h02);

    // Reset during the turn phase
    rd_addr = RD_DIR;
    wr(ADDR_DIR, 8'hFF);
    cyc(); cyc();
    chk("pre_rst_busy", 8'(busy), 8'h01);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mid_rst_oe",   cell_oe,   8'h00);
    chk("mid_rst_ie",   cell_ie,   8'hFF);
    chk("mid_rst_busy", 8'(busy),  8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    chk("post_rst_dir",   rd_data,        8'h00);
    chk("post_rst_ready", 8'(cfg_ready),  8'h01);

    // Random traffic; requests are held until accepted like a bus master
    for (int k = 0; k < 800; k++) begin
      if (!cfg_valid && ($urandom_range(0, 2) == 0)) begin
        cfg_valid = 1'b1;
        cfg_addr  = 2'($urandom_range(0, 3));
        cfg_wdata = 8'($urandom);
      end
      rd_addr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) pad = pad ^ 8'(1 << $urandom_range(0, 7));
      cyc();
      if (m_acc) cfg_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_bank_ctrl.md
Name: gpio_bank_ctrl

Overview:
- Controller for a bank of NUM_PINS bidirectional digital GPIO pad cells.
- Owns each cell's o/oe/ie controls from a small register write/read interface.
- On direction changes, sequences break-before-make turnaround so pad and core never fight.
- Synchronises pad inputs and raises a level interrupt on enabled rising edges; sits between the core's peripheral bus bridge and the pad ring.

Parameters:
- NUM_PINS, 8: number of pins in the bank (1..32).
- TURN_CYCLES, 2: idle cycles with oe=0 and ie=0 on changing pins during a direction change (>=1).
- SETTLE_CYCLES, 3: cycles after a direction change during which edge detection is masked on changed pins (>= synchroniser depth + 1).

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  write request.
- cfg_ready  out  1  controller can accept a write.
- cfg_addr  in  2  write target: 0=OUT, 1=DIR (1=output), 2=IRQ_EN, 3=IRQ_CLR (write-1-to-clear).
- cfg_wdata  in  NUM_PINS  write data.
- rd_addr  in  2  read select: 0=IN (synced), 1=DIR, 2=IRQ_EN, 3=PENDING.
- rd_data  out  NUM_PINS  combinational read of the selected register.
- busy  out  1  direction-change sequence in progress.
- irq  out  1  OR of PENDING.
- cell_o  out  NUM_PINS  to cell o.
- cell_oe  out  NUM_PINS  to cell oe.
- cell_ie  out  NUM_PINS  to cell ie.
- cell_i  in  NUM_PINS  from cell i; asynchronous to clock.

Behaviour:
- Reset (async assert, sync release):
  - OUT=0, DIR=0, IRQ_EN=0, PENDING=0.
  - cell_oe=0, cell_ie=all 1s, cell_o=0.
  - sync flops=0, settle mask=0.
  - state IDLE, cfg_ready=1, busy=0, irq=0.
- Handshake:
  - A write is accepted on a rising clock edge with cfg_valid & cfg_ready.
  - cfg_ready = (state==IDLE).
  - Registers update on the accepting edge; cell outputs reflect them from the next cycle.
- OUT write: OUT<=wdata; cell_o=OUT at all times (oe gates it at the pad).
- IRQ_EN write: replaces IRQ_EN.
- IRQ_CLR write: PENDING &= ~wdata. If a set and a clear hit the same bit in the same cycle, the set wins.
- DIR write, CHG=wdata^DIR:
  - If CHG==0: no sequence; stays IDLE.
  - Else: latch NEWDIR=wdata and CHG; go DRIVE_OFF.
- FSM:
  - IDLE: cell_oe=DIR, cell_ie=all 1s. Output pins keep ie=1 for readback.
  - DRIVE_OFF (1 cycle): cell_oe=DIR&~CHG, cell_ie=~CHG. Load turn counter with TURN_CYCLES-1; go TURN.
  - TURN: same outputs as DRIVE_OFF. Counter decrements each cycle; when it is 0, go APPLY.
  - APPLY (1 cycle): DIR<=NEWDIR; settle mask<=CHG; settle counter<=SETTLE_CYCLES; go IDLE. cell_oe/cell_ie still as in DRIVE_OFF this cycle.
  - busy=1 in DRIVE_OFF, TURN and APPLY.
  - Changed pins see oe=0 and ie=0 for exactly TURN_CYCLES+2 consecutive cycles.
  - Unchanged pins are never disturbed.
- Input path:
  - 2-flop synchroniser on cell_i gives SYNC; IN register = SYNC.
  - prev flop holds last SYNC.
  - rise = SYNC & ~prev.
- Edge qualifying: rise & IRQ_EN & ~DIR & ~settle_mask sets PENDING.
  - Edge detection is ignored on every bit during DRIVE_OFF/TURN/APPLY.
  - The settle counter decrements each cycle; at 0 the settle mask clears.
  - A new DIR sequence reloads the mask rather than ORing into it.
- irq is registered: irq = |PENDING, with one cycle of latency from the PENDING update.
- cfg_valid held while busy: the write stays pending, with no loss and no duplication, and is accepted in the first IDLE cycle.
- Reset mid-sequence: outputs return immediately to reset values; NEWDIR is discarded.
- Widths: NUM_PINS-bit vectors throughout. Counters are clog2(max(TURN_CYCLES,SETTLE_CYCLES)+1) bits wide and never wrap; they saturate at 0.

Decomposition:
- Shared package gpio_ctrl_pkg holds:
  - address constants ADDR_OUT/ADDR_DIR/ADDR_IRQ_EN/ADDR_IRQ_CLR.
  - read constants RD_IN/RD_DIR/RD_IRQ_EN/RD_PENDING.
  - state enum (IDLE, DRIVE_OFF, TURN, APPLY).
- One sub-module: gpio_sync_edge. It contains the per-vector 2-flop synchroniser plus the prev flop, and outputs SYNC and rise. It is instantiated once at NUM_PINS width.

Test Plan:
- Reset, then hold cell_i=0 -> cell_oe=0x00, cell_ie=0xFF, cell_o=0x00, irq=0, cfg_ready=1, rd_data(DIR)=0x00.
- Write OUT=0xA5, then DIR=0x0F (TURN_CYCLES=2) -> busy=1 for 4 cycles; pins 0-3 show oe=0, ie=0 for those 4 cycles; then cell_oe=0x0F and cell_o=0xA5; pins 4-7 ie stays 1 throughout.
- From DIR=0x0F, write DIR=0x3C -> pins 0,1,4,5 have oe=0/ie=0 for 4 cycles. Pins 2,3 keep oe=1 and pins 6,7 keep oe=0/ie=1 continuously. Final cell_oe=0x3C.
- IRQ_EN=0x80, DIR=0x00, cell_i[7] 0->1 -> PENDING=0x80 three cycles after the input change, irq=1 one cycle later. Same-cycle IRQ_CLR=0x80 with a new edge leaves PENDING=0x80. A later IRQ_CLR=0x80 gives PENDING=0x00 and irq=0.
- Pin 1 switched output->input while cell_i[1]=1 and IRQ_EN=0x02 -> no PENDING bit set during the sequence or settle window. A fresh 0->1 on cell_i[1] after settle sets PENDING=0x02.
- Assert reset_n=0 during TURN -> same cycle: cell_oe=0x00, cell_ie=0xFF, busy=0. After release, DIR=0x00 and cfg_ready=1.
